// File: rtl/sobel_magnitude.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sobel_magnitude
//  Description : Streaming Sobel back-end. Takes signed gx/gy gradient pairs,
//                computes the saturated L1 magnitude |gx|+|gy|, zeroes the
//                two-pixel warm-up border (first two rows and columns), and
//                emits a thresholded edge bit plus start-of-frame and
//                end-of-line markers. It is a 3-stage ready/valid pipeline in
//                which each stage can load whenever it is empty, so bubbles
//                collapse.
//
//  Ports       : clk_i     - clock
//                rstn_i    - synchronous active-low reset
//                valid_i   - gradient pair valid
//                ready_o   - block can accept a gradient pair
//                gx_i      - signed horizontal gradient (2*WIDTH_P bits)
//                gy_i      - signed vertical gradient   (2*WIDTH_P bits)
//                thresh_i  - unsigned edge threshold, sampled when the
//                            output stage loads
//                valid_o   - output pixel valid
//                ready_i   - downstream can accept
//                mag_o     - saturated magnitude (WIDTH_P bits)
//                edge_o    - magnitude >= threshold (never set on border)
//                sof_o     - output is row 0, col 0
//                eol_o     - output is the last column of a line
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_magnitude #(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [2*WIDTH_P-1:0] gx_i,
  input  logic signed [2*WIDTH_P-1:0] gy_i,
  input  logic        [WIDTH_P-1:0]   thresh_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic        [WIDTH_P-1:0]   mag_o,
  output logic                        edge_o,
  output logic                        sof_o,
  output logic                        eol_o
);

  localparam int c_GW    = 2 * WIDTH_P;      // gradient width
  localparam int c_SW    = c_GW + 1;         // sum width, cannot wrap
  localparam int c_COL_W = (DEPTH_P  > 1) ? $clog2(DEPTH_P)  : 1;
  localparam int c_ROW_W = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(DEPTH_P - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(HEIGHT_P - 1);

  // Position counters
  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;

  // Stage 1: absolute values plus position tags
  logic               r_v1;
  logic [c_GW-1:0]    r_abs_gx;
  logic [c_GW-1:0]    r_abs_gy;
  logic               r_border1;
  logic               r_sof1;
  logic               r_eol1;

  // Stage 2: full-precision sum
  logic               r_v2;
  logic [c_SW-1:0]    r_sum;
  logic               r_border2;
  logic               r_sof2;
  logic               r_eol2;

  // Stage 3: output register
  logic               r_v3;
  logic [WIDTH_P-1:0] r_mag;
  logic               r_edge;
  logic               r_sof3;
  logic               r_eol3;

  logic               w_ld1;
  logic               w_ld2;
  logic               w_ld3;
  logic               w_xfer;
  logic [c_GW-1:0]    w_abs_gx;
  logic [c_GW-1:0]    w_abs_gy;
  logic [WIDTH_P-1:0] w_sat;

  // A stage may load when it is empty or its successor is loading this cycle.
  // The chain runs combinationally from ready_i back to ready_o.
  assign w_ld3   = ~r_v3 | ready_i;
  assign w_ld2   = ~r_v2 | w_ld3;
  assign w_ld1   = ~r_v1 | w_ld2;
  assign ready_o = w_ld1;
  assign w_xfer  = valid_i & w_ld1;

  // Two's-complement negate in the same width. The most negative input maps
  // to 2^(GW-1), which is the correct magnitude when the bits are read
  // as unsigned.
  assign w_abs_gx = gx_i[c_GW-1] ? (~gx_i) + c_GW'(1) : gx_i;
  assign w_abs_gy = gy_i[c_GW-1] ? (~gy_i) + c_GW'(1) : gy_i;

  // Clamp to the output width whenever any bit above it is set
  assign w_sat = (|r_sum[c_SW-1:WIDTH_P]) ? {WIDTH_P{1'b1}} : r_sum[WIDTH_P-1:0];

  // Position counters advance only on an accepted input
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_xfer) begin
      if (r_col == c_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Stage 1
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_v1      <= 1'b0;
      r_abs_gx  <= '0;
      r_abs_gy  <= '0;
      r_border1 <= 1'b0;
      r_sof1    <= 1'b0;
      r_eol1    <= 1'b0;
    end else if (w_ld1) begin
      r_v1 <= valid_i;
      if (valid_i) begin
        r_abs_gx  <= w_abs_gx;
        r_abs_gy  <= w_abs_gy;
        r_border1 <= (r_col < 2) | (r_row < 2);
        r_sof1    <= (r_row == '0) & (r_col == '0);
        r_eol1    <= (r_col == c_COL_LAST);
      end
    end
  end

  // Stage 2
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_v2      <= 1'b0;
      r_sum     <= '0;
      r_border2 <= 1'b0;
      r_sof2    <= 1'b0;
      r_eol2    <= 1'b0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sum     <= {1'b0, r_abs_gx} + {1'b0, r_abs_gy};
        r_border2 <= r_border1;
        r_sof2    <= r_sof1;
        r_eol2    <= r_eol1;
      end
    end
  end

  // Stage 3: the output payload only changes when a real pixel moves in, so
  // bubbles never disturb the last emitted values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_v3   <= 1'b0;
      r_mag  <= '0;
      r_edge <= 1'b0;
      r_sof3 <= 1'b0;
      r_eol3 <= 1'b0;
    end else if (w_ld3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_mag  <= r_border2 ? '0 : w_sat;
        r_edge <= ~r_border2 & (w_sat >= thresh_i);
        r_sof3 <= r_sof2;
        r_eol3 <= r_eol2;
      end
    end
  end

  assign valid_o = r_v3;
  assign mag_o   = r_mag;
  assign edge_o  = r_edge;
  assign sof_o   = r_sof3;
  assign eol_o   = r_eol3;

endmodule
`default_nettype wire

// File: tb/tb_sobel_magnitude.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_magnitude
//  Description : Directed bench for sobel_magnitude. A linear sequence of
//                steps drives the input side. A negedge monitor keeps an
//                expected-output queue built from a behavioural model of the
//                magnitude/border/marker rules, pops it on every output
//                transfer, and checks that outputs hold while stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_magnitude;
  localparam int W = 8;
  localparam int D = 16;
  localparam int H = 16;

  logic                  clk = 1'b0;
  logic                  rstn_i = 1'b0;
  logic                  valid_i = 1'b0;
  logic                  ready_o;
  logic signed [2*W-1:0] gx_i = '0;
  logic signed [2*W-1:0] gy_i = '0;
  logic        [W-1:0]   thresh_i = '0;
  logic                  valid_o;
  logic                  ready_i = 1'b1;
  logic        [W-1:0]   mag_o;
  logic                  edge_o;
  logic                  sof_o;
  logic                  eol_o;

  sobel_magnitude #(.WIDTH_P(W), .DEPTH_P(D), .HEIGHT_P(H)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .gx_i(gx_i), .gy_i(gy_i), .thresh_i(thresh_i), .valid_o(valid_o),
    .ready_i(ready_i), .mag_o(mag_o), .edge_o(edge_o), .sof_o(sof_o),
    .eol_o(eol_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mag;
    int edg;
    int sof;
    int eol;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0, n_sof = 0, n_eol = 0, n_edge = 0;
  int   brow = 0, bcol = 0;
  bit   rnd = 1'b0;
  bit   prev_stall = 1'b0;
  logic [W-1:0] p_mag;
  logic p_edge, p_sof, p_eol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int gx, input int gy, input int th,
                                 input int r, input int c);
    exp_t e;
    int   ax, ay, sat;
    bit   border;
    ax     = (gx < 0) ? -gx : gx;
    ay     = (gy < 0) ? -gy : gy;
    sat    = ax + ay;
    if (sat > (1 << W) - 1) sat = (1 << W) - 1;
    border = (r < 2) || (c < 2);
    e.mag  = border ? 0 : sat;
    e.edg  = (!border && sat >= th) ? 1 : 0;
    e.sof  = (r == 0 && c == 0) ? 1 : 0;
    e.eol  = (c == D - 1) ? 1 : 0;
    return e;
  endfunction

  // Monitor: inputs are stable from 1ns after posedge, so negedge sees what
  // the next posedge will act on.
  always @(negedge clk) begin
    if (!rstn_i) begin
      q.delete();
      brow       = 0;
      bcol       = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", valid_o, 1);
        chk("stall_mag",   mag_o,   p_mag);
        chk("stall_edge",  edge_o,  p_edge);
        chk("stall_sof",   sof_o,   p_sof);
        chk("stall_eol",   eol_o,   p_eol);
      end
      if (valid_o && ready_i) begin
        exp_t e;
        n_out++;
        if (sof_o)  n_sof++;
        if (eol_o)  n_eol++;
        if (edge_o) n_edge++;
        chk("out_pending", (q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("out_mag",  mag_o,  e.mag);
          chk("out_edge", edge_o, e.edg);
          chk("out_sof",  sof_o,  e.sof);
          chk("out_eol",  eol_o,  e.eol);
        end
      end
      if (valid_i && ready_o) begin
        q.push_back(model(int'(gx_i), int'(gy_i), int'(thresh_i), brow, bcol));
        if (bcol == D - 1) begin
          bcol = 0;
          brow = (brow == H - 1) ? 0 : brow + 1;
        end else begin
          bcol = bcol + 1;
        end
      end
      prev_stall = valid_o && !ready_i;
      p_mag  = mag_o;
      p_edge = edge_o;
      p_sof  = sof_o;
      p_eol  = eol_o;
    end
  end

  // Present one pair and hold it until accepted; leaves valid_i high so
  // back-to-back calls stream at full rate.
  task automatic send(input int gx, input int gy);
    bit acc;
    int t;
    t       = 0;
    valid_i = 1'b1;
    gx_i    = 16'(gx);
    gy_i    = 16'(gy);
    forever begin
      if (rnd) ready_i = 1'($urandom_range(0, 1));
      #1;
      acc = ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        chk("accept_timeout", acc, 1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      if (rnd) ready_i = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    rstn_i  = 1'b0;
    @(posedge clk);
    #1;
    rstn_i  = 1'b1;
  endtask

  // Single pixel into an empty pipeline: checks the 3-cycle latency and the
  // emitted values directly.
  task automatic send_check(input int gx, input int gy, input int em,
                            input int ee, input int es, input int el);
    send(gx, gy);
    valid_i = 1'b0;
    chk("lat_c1_valid", valid_o, 0);
    @(posedge clk); #1;
    chk("lat_c2_valid", valid_o, 0);
    @(posedge clk); #1;
    chk("lat_c3_valid", valid_o, 1);
    chk("lat_mag",  mag_o,  em);
    chk("lat_edge", edge_o, ee);
    chk("lat_sof",  sof_o,  es);
    chk("lat_eol",  eol_o,  el);
    idle(3);
  endtask

  initial begin
    // Reset state
    thresh_i = 8'd8;
    rstn_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_mag",   mag_o,   0);
    chk("rst_edge",  edge_o,  0);
    chk("rst_sof",   sof_o,   0);
    chk("rst_eol",   eol_o,   0);
    chk("rst_ready", ready_o, 1);
    rstn_i = 1'b1;

    // Row 5 col 5: |3|+|-4| = 7 against thresholds 8 and 7
    for (int i = 0; i < 85; i++) send(0, 0);
    idle(6);
    send_check(3, -4, 7, 0, 0, 0);
    thresh_i = 8'd7;
    send_check(3, -4, 7, 1, 0, 0);

    // Saturation, still on row 5
    thresh_i = 8'd255;
    send_check(-32768, -32768, 255, 1, 0, 0);
    send_check(100, 155, 255, 1, 0, 0);
    send_check(100, 154, 254, 0, 0, 0);

    // Two full frames at full rate
    do_reset();
    thresh_i = 8'd10;
    n_out = 0; n_sof = 0; n_eol = 0; n_edge = 0;
    for (int i = 0; i < 2 * D * H; i++) send(10, 0);
    idle(8);
    chk("frame_outputs", n_out,  512);
    chk("frame_sof",     n_sof,  2);
    chk("frame_eol",     n_eol,  32);
    chk("frame_edges",   n_edge, 392);
    chk("frame_drained", q.size(), 0);

    // Backpressure: move to row 2 col 2, then stall the sink
    for (int i = 0; i < 34; i++) send(0, 0);
    idle(6);
    ready_i = 1'b0;
    send(20, 0);
    send(21, 0);
    send(22, 0);
    gx_i = 16'sd23;
    repeat (2) begin
      #1;
      chk("bp_ready_low", ready_o, 0);
      chk("bp_valid",     valid_o, 1);
      chk("bp_mag_hold",  mag_o,   20);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    for (int g = 23; g <= 30; g++) send(g, 0);
    idle(6);
    chk("bp_drained", q.size(), 0);

    // Reset mid-frame after 20 accepted pixels
    do_reset();
    thresh_i = 8'd10;
    for (int i = 0; i < 20; i++) send(50, 0);
    valid_i = 1'b0;
    rstn_i  = 1'b0;
    @(posedge clk); #1;
    rstn_i  = 1'b1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_mag",   mag_o,   0);
    send_check(77, 0, 0, 0, 1, 0);

    // Random valid/ready over three frames
    do_reset();
    thresh_i = 8'd40;
    n_out = 0;
    rnd   = 1'b1;
    for (int i = 0; i < 3 * D * H; i++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      send(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
    end
    rnd     = 1'b0;
    ready_i = 1'b1;
    idle(10);
    chk("rand_outputs", n_out, 768);
    chk("rand_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
